// File: rtl/mipsl_multicycle_control.sv
// mipsl_multicycle_control: multicycle FETCH/DECODE/EXEC/MEM/WB sequencer for MIPSL.
// Drives datapath muxes, ALU select and PC/IR write enables over a shared memory
// port with a mem_ready handshake; memory waits are bounded by MEM_TIMEOUT.
// Optional build macro: MIPSL_CTRL_PERF_EN adds retired_count/stall_count counters.
//
// state  | code | meaning
// IDLE   |  0   | waiting for run
// FETCH  |  1   | read instruction at PC, load IR and bump PC on mem_ready
// DECODE |  2   | capture opcode, reject illegal opcodes
// EXEC   |  3   | ALU operation / branch compare / address calculation
// MEM    |  4   | data load or store at ALU result address
// WB     |  5   | register file write-back, instruction retires
module mipsl_multicycle_control #(
  parameter int OPCODE_W    = 3,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                run,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                regdst,
  output logic                branch,
  output logic                memread,
  output logic                memtoreg,
  output logic                memwrite,
  output logic                alusrc,
  output logic                regwrite,
  output logic [2:0]          alu_select,
  output logic                pc_write,
  output logic                ir_write,
  output logic                iord,
  output logic [2:0]          state,
  output logic                instr_done,
  output logic                illegal_op,
  output logic                mem_err
`ifdef MIPSL_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0]    retired_count,
  output logic [CNT_W-1:0]    stall_count
`endif
);

  // Wait counter never needs to hold MEM_TIMEOUT itself: the last wait cycle aborts.
  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0]   TMO_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [OPCODE_W-1:0] MAX_OP   = OPCODE_W'(7);

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_SLT  = 3'd2;
  localparam logic [2:0] OP_LW   = 3'd3;
  localparam logic [2:0] OP_SW   = 3'd4;
  localparam logic [2:0] OP_BEQ  = 3'd5;
  localparam logic [2:0] OP_ADDI = 3'd6;
  localparam logic [2:0] OP_ANDI = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              mem_wait;
  logic              timeout;

  // Only legal opcodes (0..7) ever reach EXEC, so three bits of op_q suffice.
  assign mem_wait = ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ready;
  assign timeout  = mem_wait && (wait_q == TMO_LAST);
  assign state    = state_q;

  // Next state, latched opcode and memory wait counter.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    wait_d  = '0;
    case (state_q)
      S_IDLE: if (run) state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready)    state_d = S_DECODE;
        else if (timeout) state_d = S_FETCH;
        else              wait_d  = wait_q + WAIT_W'(1);
      end
      S_DECODE: begin
        op_d    = opcode[2:0];
        state_d = (opcode > MAX_OP) ? S_FETCH : S_EXEC;
      end
      S_EXEC: begin
        case (op_q)
          OP_LW, OP_SW: state_d = S_MEM;
          OP_BEQ:       state_d = S_FETCH;
          default:      state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (mem_ready)    state_d = (op_q == OP_LW) ? S_WB : S_FETCH;
        else if (timeout) state_d = S_FETCH;
        else              wait_d  = wait_q + WAIT_W'(1);
      end
      S_WB:    state_d = S_FETCH;
      default: state_d = S_IDLE;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      wait_q  <= wait_d;
    end
  end

  // Datapath controls decoded from state and latched opcode; all held low during
  // reset so an interrupted access issues no further writes.
  always_comb begin
    regdst     = 1'b0;
    branch     = 1'b0;
    memread    = 1'b0;
    memtoreg   = 1'b0;
    memwrite   = 1'b0;
    alusrc     = 1'b0;
    regwrite   = 1'b0;
    alu_select = 3'd0;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    iord       = 1'b0;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    mem_err    = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          memread  = 1'b1;
          ir_write = mem_ready;
          pc_write = mem_ready;
          mem_err  = timeout;
        end
        S_DECODE: illegal_op = (opcode > MAX_OP);
        S_EXEC: begin
          case (op_q)
            OP_ADD, OP_SUB, OP_SLT: alu_select = op_q;
            OP_LW, OP_SW, OP_ADDI:  alusrc = 1'b1;
            OP_ANDI: begin
              alusrc     = 1'b1;
              alu_select = 3'd4;
            end
            OP_BEQ: begin
              alu_select = 3'd1;
              branch     = 1'b1;
              instr_done = 1'b1;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          iord       = 1'b1;
          alusrc     = 1'b1;
          memread    = (op_q == OP_LW);
          memwrite   = (op_q == OP_SW);
          instr_done = (op_q == OP_SW) && mem_ready;
          mem_err    = timeout;
        end
        S_WB: begin
          regwrite   = 1'b1;
          instr_done = 1'b1;
          regdst     = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_SLT);
          memtoreg   = (op_q == OP_LW);
        end
        default: ;
      endcase
    end
  end

`ifdef MIPSL_CTRL_PERF_EN
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  // Saturating retire and memory-stall counters.
  always_comb begin
    retired_d = retired_q;
    stall_d   = stall_q;
    if (instr_done && !(&retired_q)) retired_d = retired_q + CNT_W'(1);
    if (mem_wait && !(&stall_q))     stall_d   = stall_q + CNT_W'(1);
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      retired_q <= '0;
      stall_q   <= '0;
    end else begin
      retired_q <= retired_d;
      stall_q   <= stall_d;
    end
  end

  assign retired_count = retired_q;
  assign stall_count   = stall_q;
`endif

endmodule

// File: tb/tb_mipsl_multicycle_control.sv
// tb_mipsl_multicycle_control: scoreboard bench for the MIPSL multicycle control FSM.
// The driver plans each instruction from opcode-level rules (phase sequence and
// latency table), queues the expected per-cycle controls and retire/abort events,
// and a negedge monitor pops and compares. Build with MIPSL_CTRL_PERF_EN to also
// check the performance counters.
module tb_mipsl_multicycle_control;
  localparam int OPW = 4;
  localparam int TMO = 4;
  localparam int CW  = 16;

  localparam int K_DONE = 0;
  localparam int K_ILL  = 1;
  localparam int K_ERR  = 2;

  logic           clock = 1'b0;
  logic           reset, run, mem_ready;
  logic [OPW-1:0] opcode;
  logic           regdst, branch, memread, memtoreg, memwrite, alusrc, regwrite;
  logic [2:0]     alu_select, state;
  logic           pc_write, ir_write, iord, instr_done, illegal_op, mem_err;
`ifdef MIPSL_CTRL_PERF_EN
  logic [CW-1:0]  retired_count, stall_count;
`endif

  always #5 clock = ~clock;

  mipsl_multicycle_control #(.OPCODE_W(OPW), .MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .run(run), .opcode(opcode), .mem_ready(mem_ready),
    .regdst(regdst), .branch(branch), .memread(memread), .memtoreg(memtoreg),
    .memwrite(memwrite), .alusrc(alusrc), .regwrite(regwrite),
    .alu_select(alu_select), .pc_write(pc_write), .ir_write(ir_write), .iord(iord),
    .state(state), .instr_done(instr_done), .illegal_op(illegal_op), .mem_err(mem_err)
`ifdef MIPSL_CTRL_PERF_EN
    , .retired_count(retired_count), .stall_count(stall_count)
`endif
  );

  typedef struct { logic [2:0] st; logic [15:0] vec; bit skip; } cyc_rec_t;
  typedef struct { int kind; int at; } ev_t;

  cyc_rec_t cycq[$];
  ev_t      evq[$];
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int exp_ret = 0;
  int exp_stall = 0;
  bit perf_pending = 0;

  // Per-opcode behaviour: add sub slt lw sw beq addi andi
  int sel_tab    [8] = '{0, 1, 2, 0, 0, 1, 0, 4};
  bit alusrc_tab [8] = '{0, 0, 0, 1, 1, 0, 1, 1};
  int lat_tab    [8] = '{4, 4, 4, 5, 4, 3, 4, 4};

  logic [15:0] act;
  assign act = {regdst, branch, memread, memtoreg, memwrite, alusrc, regwrite,
                alu_select, pc_write, ir_write, iord, instr_done, illegal_op, mem_err};

  // Expected control word for one cycle of a given phase (1 fetch .. 5 wb).
  function automatic logic [15:0] ctrl_vec(int ph, int op, bit rdy, bit ab);
    logic rd, br, mr, mt, mw, as, rw, pw, iw, io, dn, il, er;
    logic [2:0] sel;
    {rd, br, mr, mt, mw, as, rw, pw, iw, io, dn, il, er} = '0;
    sel = 3'd0;
    case (ph)
      1: begin mr = 1; iw = rdy; pw = rdy; er = ab; end
      2: il = (op > 7);
      3: begin
        as  = alusrc_tab[op & 7];
        sel = 3'(sel_tab[op & 7]);
        br  = (op == 5);
        dn  = (op == 5);
      end
      4: begin
        io = 1; as = 1;
        mr = (op == 3); mw = (op == 4);
        dn = (op == 4) && rdy; er = ab;
      end
      5: begin rw = 1; dn = 1; rd = (op < 3); mt = (op == 3); end
      default: ;
    endcase
    return {rd, br, mr, mt, mw, as, rw, sel, pw, iw, io, dn, il, er};
  endfunction

  function automatic int pick_wait();
    int r;
    r = $urandom_range(0, 9);
    if (r < 5) return 0;
    if (r < 9) return $urandom_range(1, TMO - 1);
    return TMO;
  endfunction

  task automatic drive_cycle(input logic [2:0] st, input int opc, input bit rdy,
                             input logic [15:0] vec, input bit rst, input bit skip,
                             input bit run_v);
    cyc_rec_t r;
    @(posedge clock);
    #1;
    cyc++;
`ifdef MIPSL_CTRL_PERF_EN
    if (perf_pending) begin
      perf_pending = 0;
      n_chk++;
      if (retired_count !== CW'(exp_ret)) begin
        n_fail++;
        $display("FAIL retired_count got=%0d want=%0d", retired_count, exp_ret);
      end
      n_chk++;
      if (stall_count !== CW'(exp_stall)) begin
        n_fail++;
        $display("FAIL stall_count got=%0d want=%0d", stall_count, exp_stall);
      end
    end
`endif
    reset     = rst;
    run       = run_v;
    mem_ready = rdy;
    opcode    = OPW'(opc);
    r.st = st; r.vec = vec; r.skip = skip;
    cycq.push_back(r);
    if (rst) begin
      exp_ret   = 0;
      exp_stall = 0;
    end else begin
      if (vec[2]) exp_ret++;
      if ((st == 3'd1 || st == 3'd4) && !rdy) exp_stall++;
    end
  endtask

  // One non-idle cycle; the opcode bus carries noise except in DECODE.
  task automatic phase(input int st, input int op, input bit rdy, input bit ab);
    int opc;
    opc = (st == 2) ? op : int'($urandom_range(0, 15));
    drive_cycle(3'(st), opc, rdy, ctrl_vec(st, op, rdy, ab), 1'b0, 1'b0,
                1'($urandom_range(0, 1)));
  endtask

  task automatic mem_access(input int st, input int op, input int waits, output bit aborted);
    aborted = (waits >= TMO);
    for (int j = 0; j <= waits && j < TMO; j++)
      phase(st, op, (!aborted && j == waits), (aborted && j == TMO - 1));
  endtask

  task automatic run_instr(input int op, input int fw, input int mw);
    ev_t e;
    int  start;
    bit  ab;
    bit  is_mem;
    start  = cyc + 1;
    is_mem = (op == 3 || op == 4);
    e.kind = K_DONE;
    if (fw >= TMO) begin
      e.kind = K_ERR; e.at = start + TMO - 1;
    end else if (op > 7) begin
      e.kind = K_ILL; e.at = start + fw + 1;
    end else if (is_mem && mw >= TMO) begin
      e.kind = K_ERR; e.at = start + fw + 3 + TMO - 1;
    end else begin
      e.at = start + fw + (is_mem ? mw : 0) + lat_tab[op] - 1;
    end
    evq.push_back(e);
    mem_access(1, op, fw, ab);
    if (ab) return;
    phase(2, op, 1'($urandom_range(0, 1)), 1'b0);
    if (op > 7) return;
    phase(3, op, 1'($urandom_range(0, 1)), 1'b0);
    if (op == 5) return;
    if (is_mem) begin
      mem_access(4, op, mw, ab);
      if (ab || op == 4) return;
    end
    phase(5, op, 1'($urandom_range(0, 1)), 1'b0);
  endtask

  // Monitor: per-cycle control check and event scoreboard.
  always @(negedge clock) begin
    cyc_rec_t r;
    ev_t      e;
    int       k;
    if (cycq.size() > 0) begin
      r = cycq.pop_front();
      if (!r.skip) begin
        n_chk++;
        if (state !== r.st) begin
          n_fail++;
          $display("FAIL state cyc=%0d got=%0d want=%0d", cyc, state, r.st);
        end
        n_chk++;
        if (act !== r.vec) begin
          n_fail++;
          $display("FAIL ctrl cyc=%0d got=%h want=%h", cyc, act, r.vec);
        end
      end
    end
    if (instr_done === 1'b1 || illegal_op === 1'b1 || mem_err === 1'b1) begin
      k = instr_done ? K_DONE : (illegal_op ? K_ILL : K_ERR);
      n_chk++;
      if (evq.size() == 0) begin
        n_fail++;
        $display("FAIL event unexpected cyc=%0d got kind=%0d want none", cyc, k);
      end else begin
        e = evq.pop_front();
        if (e.kind != k || e.at != cyc) begin
          n_fail++;
          $display("FAIL event got kind=%0d cyc=%0d want kind=%0d cyc=%0d", k, cyc, e.kind, e.at);
        end
      end
    end
  end

  initial begin
    reset = 1; run = 0; mem_ready = 0; opcode = '0;
    @(posedge clock);
    drive_cycle(3'd0, 0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    drive_cycle(3'd0, 0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    drive_cycle(3'd0, 0, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0);
    drive_cycle(3'd0, 5, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0);
    drive_cycle(3'd0, 0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);

    run_instr(4, 1, 0);
    run_instr(4, 0, 0);
    run_instr(3, 0, 1);
    perf_pending = 1;

    run_instr(0, 0, 0);
    run_instr(3, 0, 3);
    run_instr(5, 0, 0);
    run_instr(0, TMO, 0);
    run_instr(9, 0, 0);
    run_instr(4, 0, TMO);
    run_instr(3, 2, TMO - 1);
    run_instr(7, 2, 0);
    run_instr(6, 0, 0);
    run_instr(1, 1, 0);
    run_instr(2, TMO - 1, 0);
    run_instr(15, 0, 0);

    for (int i = 0; i < 200; i++) begin
      int op, fw, mw;
      op = $urandom_range(0, 11);
      fw = pick_wait();
      mw = pick_wait();
      run_instr(op, fw, mw);
    end
    perf_pending = 1;

    phase(1, 3, 1'b1, 1'b0);
    phase(2, 3, 1'b0, 1'b0);
    phase(3, 3, 1'b0, 1'b0);
    phase(4, 3, 1'b0, 1'b0);
    drive_cycle(3'd4, 0, 1'b1, 16'h0, 1'b1, 1'b1, 1'b0);
    perf_pending = 1;
    drive_cycle(3'd0, 3, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0);
    drive_cycle(3'd0, 3, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0);
    drive_cycle(3'd0, 3, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);

    @(negedge clock);
    #1;
    n_chk++;
    if (evq.size() != 0) begin
      n_fail++;
      $display("FAIL events_pending got=%0d want=0", evq.size());
    end
    n_chk++;
    if (cycq.size() != 0) begin
      n_fail++;
      $display("FAIL cycles_pending got=%0d want=0", cycq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
